// File: rtl/ram_sdp_param_if.sv
// Bus bundle for ram_sdp_param: write port, read port and clear status.
interface ram_sdp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with byte enables, 1-cycle registered read and a post-reset clear sweep.
// Define RAM_SDP_WR_FWD_EN for write-first forwarding on same-address same-cycle collisions.
module ram_sdp_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    ram_sdp_param_if.slave bus
);
    localparam int                NB   = DATA_W / 8;
    localparam int                AW1  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic              wr_in_range, rd_in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;
    logic              rd_fire;
    logic              rd_valid_reg;
    logic              rd_zero_reg;
    logic [DATA_W-1:0] rd_data_w;

    assign wr_in_range = ({1'b0, bus.wr_addr} < AW1'(DEPTH));
    assign rd_in_range = ({1'b0, bus.rd_addr} < AW1'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The clear sweep borrows the write port; user requests are ignored until READY.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;
        mem_be     = bus.wr_be;
        rd_fire    = 1'b0;
        case (state_reg)
            CLEAR: begin
                mem_we    = !rst;
                mem_waddr = cnt_reg;
                mem_wdata = INIT_VAL;
                mem_be    = '1;
                cnt_next  = cnt_reg + ADDR_W'(1);
                if (cnt_reg == LAST)
                    state_next = READY;
            end
            READY: begin
                mem_we  = !rst && bus.wr_en && wr_in_range;
                rd_fire = !rst && bus.rd_en;
            end
            default: state_next = CLEAR;
        endcase
    end

    // rd_zero_reg forces 0 after reset and for out-of-range reads, keeping the RAM output reg reset-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
        end else begin
            rd_valid_reg <= rd_fire;
            if (rd_fire)
                rd_zero_reg <= !rd_in_range;
        end
    end

`ifdef RAM_SDP_WR_FWD_EN
    logic collision;
    assign collision = mem_we && (state_reg == READY) && (bus.wr_addr == bus.rd_addr);
`endif

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q_reg;

        always_ff @(posedge clk) begin
            if (mem_we && mem_be[gi])
                mem[mem_waddr] <= mem_wdata[8*gi +: 8];
            if (rd_fire && rd_in_range)
                rd_q_reg <= mem[bus.rd_addr];
        end

`ifdef RAM_SDP_WR_FWD_EN
        logic       fwd_reg;
        logic [7:0] fwd_byte_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                fwd_reg      <= 1'b0;
                fwd_byte_reg <= 8'h00;
            end else if (rd_fire) begin
                fwd_reg      <= collision && mem_be[gi];
                fwd_byte_reg <= mem_wdata[8*gi +: 8];
            end
        end

        assign rd_data_w[8*gi +: 8] = rd_zero_reg ? 8'h00 : (fwd_reg ? fwd_byte_reg : rd_q_reg);
`else
        assign rd_data_w[8*gi +: 8] = rd_zero_reg ? 8'h00 : rd_q_reg;
`endif
    end

    assign bus.rd_data   = rd_data_w;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.init_busy = (state_reg == CLEAR);
endmodule
